// File: rtl/task_ctrl_param.sv
// Per-task scheduler slot: decodes the shared op bus, holds state/priority/hit budget, emits sort key.
// Optional priority aging is enabled by defining TASK_AGING_EN.
module task_ctrl_param #(
  parameter int unsigned TASK_ID   = 5,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned PRIO_W    = 4,
  parameter int unsigned HIT_W     = 8,
  parameter int unsigned HIT_INIT  = 'h80,
  parameter int unsigned AGE_LIMIT = 10000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [15:0]            in_op,
  input  logic                   in_op_valid,
  output logic                   op_ack,
  output logic [ID_W+PRIO_W-1:0] out_sorter,
  output logic                   out_valid,
  output logic [1:0]             task_state,
  output logic [HIT_W-1:0]       exe_hit
);

  if (ID_W > 4 || PRIO_W < 4 || HIT_W < 4 || AGE_LIMIT < 2) begin : g_bad_params
    $error("task_ctrl_param: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    StReady = 2'b00,
    StSusp  = 2'b01,
    StWait  = 2'b10,
    StTerm  = 2'b11
  } state_e;

  state_e            state_q;
  logic [PRIO_W-1:0] prio_q;
  logic [HIT_W-1:0]  hit_q;

  logic       addressed;
  logic       eligible;
  logic       exec_ok;
  logic [3:0] opcode;
  logic [3:0] operand;

  // Reserved bits of the op word carry no meaning for this slot.
  logic unused_rsvd;
  assign unused_rsvd = ^in_op[15:12];

  always_comb begin
    opcode    = in_op[7:4];
    operand   = in_op[3:0];
    addressed = in_op_valid && (in_op[11:8] == 4'(TASK_ID));
    eligible  = (state_q == StReady) && (hit_q != '0);
    exec_ok   = addressed && eligible && ((opcode == 4'b0111) || (opcode == 4'b1111));
  end

`ifdef TASK_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT);
  logic [AGE_W-1:0] age_q;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StReady;
      prio_q     <= '0;
      hit_q      <= HIT_W'(HIT_INIT);
      op_ack     <= 1'b0;
      out_valid  <= 1'b0;
      out_sorter <= '0;
`ifdef TASK_AGING_EN
      age_q      <= '0;
`endif
    end else begin
      op_ack     <= addressed;
      // Key follows the registered state, so it trails an accepted op by one cycle.
      out_valid  <= eligible;
      out_sorter <= eligible ? {ID_W'(TASK_ID), prio_q} : '0;

`ifdef TASK_AGING_EN
      // Placed before op decode so a same-cycle priority write overrides the increment.
      if (!eligible || exec_ok) begin
        age_q <= '0;
      end else if (age_q == AGE_W'(AGE_LIMIT - 1)) begin
        age_q <= '0;
        if (prio_q != '1) prio_q <= prio_q + PRIO_W'(1);
      end else begin
        age_q <= age_q + AGE_W'(1);
      end
`endif

      if (addressed && (state_q != StTerm)) begin
        case (opcode)
          4'b0001:          state_q <= StReady;
          4'b0010:          state_q <= StSusp;
          4'b0011:          state_q <= StWait;
          4'b0100, 4'b1100: state_q <= StTerm;
          4'b0101:          prio_q  <= PRIO_W'(operand);
          4'b0110:          hit_q   <= HIT_W'(operand);
          4'b0111, 4'b1111: begin
            if (exec_ok) begin
              hit_q <= hit_q - HIT_W'(1);
              if ((opcode == 4'b1111) && (hit_q == HIT_W'(1))) state_q <= StWait;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign task_state = state_q;
  assign exe_hit    = hit_q;

endmodule

// File: tb/tb_task_ctrl_param.sv
// Scoreboard bench for task_ctrl_param: expected observations are queued per driven cycle and
// compared one edge later against {op_ack, task_state, exe_hit, out_valid, out_sorter}.
module tb_task_ctrl_param;

  logic        CLK;
  logic        RST_N;
  logic [15:0] in_op;
  logic        in_op_valid;

  logic        op_ack,  a_op_ack;
  logic [7:0]  out_sorter, a_out_sorter;
  logic        out_valid, a_out_valid;
  logic [1:0]  task_state, a_task_state;
  logic [7:0]  exe_hit, a_exe_hit;

  int checks   = 0;
  int failures = 0;

  logic [19:0] exp_q[$];

`ifdef TASK_AGING_EN
  localparam logic [7:0] AgedF = 8'h5F;
  localparam logic [7:0] AgedE = 8'h5E;
`else
  localparam logic [7:0] AgedF = 8'h5E;
  localparam logic [7:0] AgedE = 8'h5D;
`endif

  task_ctrl_param u_dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_op       (in_op),
    .in_op_valid (in_op_valid),
    .op_ack      (op_ack),
    .out_sorter  (out_sorter),
    .out_valid   (out_valid),
    .task_state  (task_state),
    .exe_hit     (exe_hit)
  );

  // Short aging period instance, sharing the same input bus.
  task_ctrl_param #(.AGE_LIMIT(4)) u_age (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_op       (in_op),
    .in_op_valid (in_op_valid),
    .op_ack      (a_op_ack),
    .out_sorter  (a_out_sorter),
    .out_valid   (a_out_valid),
    .task_state  (a_task_state),
    .exe_hit     (a_exe_hit)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] obs_main();
    return {op_ack, task_state, exe_hit, out_valid, out_sorter};
  endfunction

  function automatic logic [19:0] obs_age();
    return {a_op_ack, a_task_state, a_exe_hit, a_out_valid, a_out_sorter};
  endfunction

  // Drive one cycle from the falling edge, then return at the next falling edge.
  task automatic tick(input logic rst, input logic v, input logic [15:0] op);
    RST_N       = rst;
    in_op_valid = v;
    in_op       = op;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Row: {rst_n, valid, op[15:0], ack, state[1:0], hit[7:0], out_valid, out_sorter[7:0]}
  task automatic test_reset();
    logic [37:0] rows [3];
    logic [19:0] got, want;
    rows = '{
      {1'b0, 1'b1, 16'h0520, 1'b0, 2'd0, 8'h80, 1'b0, 8'h00},
      {1'b0, 1'b1, 16'h0520, 1'b0, 2'd0, 8'h80, 1'b0, 8'h00},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b1, 8'h50}
    };
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(rows[i][19:0]);
      tick(rows[i][37], rows[i][36], rows[i][35:20]);
      got  = obs_main();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_addressing();
    logic [37:0] rows [7];
    logic [19:0] got, want;
    rows = '{
      {1'b1, 1'b1, 16'h0620, 1'b0, 2'd0, 8'h80, 1'b1, 8'h50},
      {1'b1, 1'b0, 16'h0520, 1'b0, 2'd0, 8'h80, 1'b1, 8'h50},
      {1'b1, 1'b1, 16'h0520, 1'b1, 2'd1, 8'h80, 1'b1, 8'h50},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd1, 8'h80, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'h0580, 1'b1, 2'd1, 8'h80, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'hF510, 1'b1, 2'd0, 8'h80, 1'b0, 8'h00},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b1, 8'h50}
    };
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(rows[i][19:0]);
      tick(rows[i][37], rows[i][36], rows[i][35:20]);
      got  = obs_main();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL addressing[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_prio_hit();
    logic [37:0] rows [6];
    logic [19:0] got, want;
    rows = '{
      {1'b1, 1'b1, 16'h0557, 1'b1, 2'd0, 8'h80, 1'b1, 8'h50},
      {1'b1, 1'b1, 16'h0562, 1'b1, 2'd0, 8'h02, 1'b1, 8'h57},
      {1'b1, 1'b1, 16'h0570, 1'b1, 2'd0, 8'h01, 1'b1, 8'h57},
      {1'b1, 1'b1, 16'h0570, 1'b1, 2'd0, 8'h00, 1'b1, 8'h57},
      {1'b1, 1'b1, 16'h0570, 1'b1, 2'd0, 8'h00, 1'b0, 8'h00},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00}
    };
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(rows[i][19:0]);
      tick(rows[i][37], rows[i][36], rows[i][35:20]);
      got  = obs_main();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL prio_hit[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_finish();
    logic [37:0] rows [3];
    logic [19:0] got, want;
    rows = '{
      {1'b1, 1'b1, 16'h0561, 1'b1, 2'd0, 8'h01, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'h05F0, 1'b1, 2'd2, 8'h00, 1'b1, 8'h57},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd2, 8'h00, 1'b0, 8'h00}
    };
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(rows[i][19:0]);
      tick(rows[i][37], rows[i][36], rows[i][35:20]);
      got  = obs_main();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL finish[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_kill_sticky();
    logic [37:0] rows [7];
    logic [19:0] got, want;
    rows = '{
      {1'b1, 1'b1, 16'h0510, 1'b1, 2'd0, 8'h00, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'h05C0, 1'b1, 2'd3, 8'h00, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'h0510, 1'b1, 2'd3, 8'h00, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'h0563, 1'b1, 2'd3, 8'h00, 1'b0, 8'h00},
      {1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'h0540, 1'b1, 2'd3, 8'h80, 1'b1, 8'h50},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd3, 8'h80, 1'b0, 8'h00}
    };
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(rows[i][19:0]);
      tick(rows[i][37], rows[i][36], rows[i][35:20]);
      got  = obs_main();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL kill_sticky[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] rows [8];
    logic [19:0] got, want;
    rows = '{
      {1'b0, 1'b1, 16'h0540, 1'b0, 2'd0, 8'h80, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'h0520, 1'b1, 2'd1, 8'h80, 1'b1, 8'h50},
      {1'b1, 1'b1, 16'h0510, 1'b1, 2'd0, 8'h80, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'h0559, 1'b1, 2'd0, 8'h80, 1'b1, 8'h50},
      {1'b1, 1'b1, 16'h0530, 1'b1, 2'd2, 8'h80, 1'b1, 8'h59},
      {1'b1, 1'b1, 16'h0400, 1'b0, 2'd2, 8'h80, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'h0570, 1'b1, 2'd2, 8'h80, 1'b0, 8'h00},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd2, 8'h80, 1'b0, 8'h00}
    };
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(rows[i][19:0]);
      tick(rows[i][37], rows[i][36], rows[i][35:20]);
      got  = obs_main();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  // Observes the AGE_LIMIT=4 instance; without aging the priority must never move on its own.
  task automatic test_aging();
    logic [37:0] rows [17];
    logic [19:0] got, want;
    rows = '{
      {1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b0, 8'h00},
      {1'b1, 1'b1, 16'h055E, 1'b1, 2'd0, 8'h80, 1'b1, 8'h50},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b1, 8'h5E},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b1, 8'h5E},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b1, 8'h5E},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b1, AgedF},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b1, AgedF},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b1, AgedF},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b1, AgedF},
      {1'b1, 1'b1, 16'h055D, 1'b1, 2'd0, 8'h80, 1'b1, AgedF},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h80, 1'b1, 8'h5D},
      {1'b1, 1'b1, 16'h0570, 1'b1, 2'd0, 8'h7F, 1'b1, 8'h5D},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h7F, 1'b1, 8'h5D},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h7F, 1'b1, 8'h5D},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h7F, 1'b1, 8'h5D},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h7F, 1'b1, 8'h5D},
      {1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 8'h7F, 1'b1, AgedE}
    };
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(rows[i][19:0]);
      tick(rows[i][37], rows[i][36], rows[i][35:20]);
      got  = obs_age();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL aging[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    RST_N       = 1'b0;
    in_op       = 16'h0000;
    in_op_valid = 1'b0;
    @(negedge CLK);
    test_reset();
    test_addressing();
    test_prio_hit();
    test_finish();
    test_kill_sticky();
    test_back_to_back();
    test_aging();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
